// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting one requester at a time ownership of a shared timer_counter.
// Latency: the grant appears 1 cycle after selection, and done appears after LOAD plus `ticks` overflows plus 1 cycle.
// Backpressure: requesters hold req high until done. Dropping req during RUN abandons the grant without a done pulse.
module timer_arbiter #(
    parameter int M_BITS    = 4,
    parameter int TICK_BITS = 8,
    parameter int N_REQ     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*M_BITS-1:0]    period,
    input  logic [N_REQ*TICK_BITS-1:0] ticks,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           done,
    output logic                       busy,
    output logic [M_BITS-1:0]          tmr_m,
    output logic                       tmr_reset,
    input  logic                       tmr_of
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     last_owner_q;
    logic [M_BITS-1:0]    tmr_m_q;
    logic [TICK_BITS-1:0] remaining_q;

    logic                 sel_vld;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     cand_idx;
    int                   cand;
    logic [N_REQ-1:0]     owner_onehot;

    // Unpack the per-requester slices so they can be indexed by requester number
    logic [M_BITS-1:0]    period_arr [N_REQ];
    logic [TICK_BITS-1:0] ticks_arr  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign period_arr[g] = period[g*M_BITS +: M_BITS];
        assign ticks_arr[g]  = ticks[g*TICK_BITS +: TICK_BITS];
    end

    // Round-robin pick: the first asserted req at or after last_owner+1, wrapping
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(last_owner_q) + 1 + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!sel_vld && req[cand_idx]) begin
                sel_vld = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. An abandoned request outranks a coincident overflow.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = (remaining_q != '0) ? RUN : DONE;
            end
            RUN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                end else if (tmr_of && (remaining_q == TICK_BITS'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Owner, timer modulus and overflow countdown.
    // These are captured only at selection, so later input changes do not affect the current grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            tmr_m_q      <= '0;
            remaining_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        owner_q     <= sel_idx;
                        tmr_m_q     <= period_arr[sel_idx];
                        remaining_q <= ticks_arr[sel_idx];
                    end
                end
                RUN: begin
                    if (!req[owner_q]) begin
                        last_owner_q <= owner_q;
                    end else if (tmr_of) begin
                        remaining_q <= remaining_q - TICK_BITS'(1);
                    end
                end
                DONE: begin
                    last_owner_q <= owner_q;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from registered state.
    // tmr_reset also follows reset so the timer is cleared while the arbiter is held in reset.
    always_comb begin
        owner_onehot = N_REQ'(1) << owner_q;
        grant        = (state_q != IDLE) ? owner_onehot : '0;
        done         = (state_q == DONE) ? owner_onehot : '0;
        busy         = (state_q != IDLE);
        tmr_reset    = reset || (state_q == LOAD);
        tmr_m        = tmr_m_q;
    end

endmodule
